// File: rtl/serial_add_unit.sv
// rtl/serial_add_unit.sv - bit-serial adder/subtractor, one bit per clock, LSB first
// Optional macro SERIAL_ADD_ACC_EN adds acc_sel to accumulate into the sum register.
module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_ACC_EN
    input  logic             acc_sel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_load;
    logic [WIDTH-1:0] w_res_next;
    logic             w_s;
    logic             w_carry_next;

`ifdef SERIAL_ADD_ACC_EN
    assign w_a_load = acc_sel ? r_sum : a;
`else
    assign w_a_load = a;
`endif

    // Single full-adder cell; the carry flop closes the loop between bits.
    assign w_s          = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_carry_next = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
    assign w_res_next   = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: the +1 rides in on the initial carry.
                        r_a_sr  <= w_a_load;
                        r_b_sr  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_carry <= w_carry_next;
                    r_res   <= w_res_next;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_carry_next;
                        r_ovf   <= r_carry ^ w_carry_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
